m_shift_seq: RTL and testbench

//  Parametrised multiplier/shift register with a built-in shift sequencer. It holds a W-bit

---
 rtl/m_shift_seq.sv | 173 +++++++++++++++++
 tb/tb_m_shift_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_shift_seq.sv
// m_shift_seq: W-bit shift/rotate register with an autonomous step sequencer.
// Vector bit W-1 holds the word MSB (architectural m[0]); t follows the same mapping.
module m_shift_seq #(
    parameter int W  = 40,
    parameter int CW = 6
) (
    input  logic          clk_sys_i,
    input  logic          reset_n_i,
    input  logic          start_i,
    input  logic [2:0]    op_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [W-1:0]  t_i,
    input  logic          sin_r_i,
    input  logic          sin_l_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  m_o,
    output logic          m_ext_o,
    output logic          ovf_o
);
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR_L = 3'b010;
    localparam logic [2:0] OP_SHR_A = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  m_q, m_d;
    logic          ext_q, ext_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    op_q, op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic is_step_op(input logic [2:0] op);
        return (op >= OP_SHR_L) && (op <= OP_ROL);
    endfunction

    // State register
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; reserved op 111 falls through to DONE like NOP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_step_op(op_i)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rem_q == {CW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs derived from the upcoming state so they land registered
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Datapath next value: capture on accept, one step per RUN cycle while rem != 0
    always_comb begin
        m_d   = m_q;
        ext_d = ext_q;
        ovf_d = ovf_q;
        rem_d = rem_q;
        op_d  = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    rem_d = cnt_i;
                    ovf_d = 1'b0;
                    if (op_i == OP_LOAD) begin
                        m_d = t_i;
                    end else begin
                        m_d = m_q;
                    end
                end else begin
                    m_d = m_q;
                end
            end
            ST_RUN: begin
                if (rem_q != {CW{1'b0}}) begin
                    rem_d = rem_q - CW'(1);
                    case (op_q)
                        OP_SHR_L: begin
                            m_d   = {sin_r_i, m_q[W-1:1]};
                            ext_d = m_q[0];
                        end
                        OP_SHR_A: begin
                            m_d   = {m_q[W-1], m_q[W-1:1]};
                            ext_d = m_q[0];
                        end
                        OP_SHL: begin
                            m_d   = {m_q[W-2:0], sin_l_i};
                            ext_d = m_q[W-1];
                            ovf_d = ovf_q | (m_q[W-1] ^ m_q[W-2]);
                        end
                        OP_ROR: begin
                            m_d   = {m_q[0], m_q[W-1:1]};
                            ext_d = m_q[0];
                        end
                        OP_ROL: begin
                            m_d   = {m_q[W-2:0], m_q[W-1]};
                            ext_d = m_q[W-1];
                        end
                        default: m_d = m_q;
                    endcase
                end else begin
                    rem_d = rem_q;
                end
            end
            default: m_d = m_q;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_q    <= {W{1'b0}};
            ext_q  <= 1'b0;
            ovf_q  <= 1'b0;
            rem_q  <= {CW{1'b0}};
            op_q   <= 3'b000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            ext_q  <= ext_d;
            ovf_q  <= ovf_d;
            rem_q  <= rem_d;
            op_q   <= op_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign m_o     = m_q;
    assign m_ext_o = ext_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_m_shift_seq.sv
// Self-checking bench for m_shift_seq: a bit-array reference model pushes expected
// results into a scoreboard queue; each scenario task pops and compares them.
module tb_m_shift_seq;
    localparam int W  = 40;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [CW-1:0] cnt = 6'd0;
    logic [W-1:0]  t = 40'h0;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic          busy_o, done_o, m_ext_o, ovf_o;
    logic [W-1:0]  m_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] m;
        logic         ext;
        logic         ovf;
        int           lat;
        int           busy_n;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mdl_m = 40'h0;
    logic         mdl_ext = 1'b0;
    logic         mdl_ovf = 1'b0;
    int           obs_lat, obs_busy, obs_done;

    m_shift_seq #(.W(W), .CW(CW)) dut (
        .clk_sys_i(clk), .reset_n_i(rst_n), .start_i(start), .op_i(op), .cnt_i(cnt),
        .t_i(t), .sin_r_i(sin_r), .sin_l_i(sin_l), .busy_o(busy_o), .done_o(done_o),
        .m_o(m_o), .m_ext_o(m_ext_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // Reference model working on the architectural index order (idx 0 = MSB).
    task automatic model_op(input logic [2:0] o, input int c, input logic [W-1:0] d,
                            input logic sr, input logic sl, output exp_t e);
        logic mm[0:W-1];
        logic outb;
        bit   step;
        step = (o >= 3'd2) && (o <= 3'd6);
        mdl_ovf = 1'b0;
        if (o == 3'd1) mdl_m = d;
        for (int i = 0; i < W; i++) mm[i] = mdl_m[W-1-i];
        if (step) begin
            for (int s = 0; s < c; s++) begin
                if (o == 3'd4 || o == 3'd6) begin
                    if (o == 3'd4) mdl_ovf = mdl_ovf | (mm[0] ^ mm[1]);
                    outb = mm[0];
                    for (int i = 0; i < W-1; i++) mm[i] = mm[i+1];
                    mm[W-1] = (o == 3'd4) ? sl : outb;
                end else begin
                    outb = mm[W-1];
                    for (int i = W-1; i > 0; i--) mm[i] = mm[i-1];
                    mm[0] = (o == 3'd2) ? sr : (o == 3'd3) ? mm[1] : outb;
                end
                mdl_ext = outb;
            end
            for (int i = 0; i < W; i++) mdl_m[W-1-i] = mm[i];
        end
        e.m      = mdl_m;
        e.ext    = mdl_ext;
        e.ovf    = mdl_ovf;
        e.lat    = step ? c + 1 : 0;
        e.busy_n = step ? c + 2 : 1;
    endtask

    // Drive one command, push its expectation, then watch busy/done with a cycle bound.
    task automatic issue(input logic [2:0] o, input int c, input logic [W-1:0] d,
                         input logic sr, input logic sl, input bit poke);
        exp_t e;
        bit   seen;
        model_op(o, c, d, sr, sl, e);
        sb.push_back(e);
        op = o; cnt = c[CW-1:0]; t = d; sin_r = sr; sin_l = sl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7)); cnt = 6'($urandom); t = {8'($urandom), 32'($urandom)};
        obs_lat = -1; obs_busy = 0; obs_done = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy_o) obs_busy++;
            if (done_o) begin
                obs_done++;
                if (!seen) begin seen = 1; obs_lat = i; end
            end
            if (!busy_o) break;
            if (poke) begin start = 1'b1; op = 3'b001; t = {8'($urandom), 32'($urandom)}; end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({m_o, m_ext_o, ovf_o, busy_o, done_o} !== 44'h0) begin
            errors++; $display("FAIL reset_state: got m=%h ext=%b ovf=%b busy=%b done=%b, want all 0",
                               m_o, m_ext_o, ovf_o, busy_o, done_o);
        end
        op = 3'd2; cnt = 6'd20; sin_r = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1 || m_o !== 40'hF8_0000_0000) begin
            errors++; $display("FAIL reset_prerun: got busy=%b m=%h, want 1 f800000000", busy_o, m_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({m_o, m_ext_o, ovf_o, busy_o, done_o} !== 44'h0) begin
            errors++; $display("FAIL reset_async: got m=%h ext=%b ovf=%b busy=%b done=%b, want all 0",
                               m_o, m_ext_o, ovf_o, busy_o, done_o);
        end
        obs_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            if (done_o) obs_done++;
        end
        checks++; if (obs_done !== 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_no_done: got done pulses=%0d busy=%b, want 0 0", obs_done, busy_o);
        end
        mdl_m = 40'h0; mdl_ext = 1'b0; mdl_ovf = 1'b0;
    endtask

    task automatic test_arith_shift();
        exp_t e;
        issue(3'd1, 0, 40'h80_0000_0001, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || obs_lat !== e.lat || obs_busy !== e.busy_n) begin
            errors++; $display("FAIL load: got m=%h lat=%0d busy=%0d, want %h %0d %0d",
                               m_o, obs_lat, obs_busy, e.m, e.lat, e.busy_n);
        end
        issue(3'd3, 4, 40'h0, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || m_ext_o !== e.ext) begin
            errors++; $display("FAIL sra_data: got m=%h ext=%b, want %h %b", m_o, m_ext_o, e.m, e.ext);
        end
        checks++; if (obs_lat !== e.lat || obs_busy !== e.busy_n || obs_done !== 1) begin
            errors++; $display("FAIL sra_timing: got lat=%0d busy=%0d done=%0d, want %0d %0d 1",
                               obs_lat, obs_busy, obs_done, e.lat, e.busy_n);
        end
    endtask

    task automatic test_logical_shift();
        exp_t e;
        issue(3'd1, 0, 40'h0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        issue(3'd2, 8, 40'h0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || m_ext_o !== e.ext || obs_lat !== e.lat) begin
            errors++; $display("FAIL shr_log: got m=%h ext=%b lat=%0d, want %h %b %0d",
                               m_o, m_ext_o, obs_lat, e.m, e.ext, e.lat);
        end
        issue(3'd2, 0, 40'h0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || obs_lat !== e.lat || obs_busy !== e.busy_n) begin
            errors++; $display("FAIL shr_cnt0: got m=%h lat=%0d busy=%0d, want %h %0d %0d",
                               m_o, obs_lat, obs_busy, e.m, e.lat, e.busy_n);
        end
    endtask

    task automatic test_shl_ovf();
        exp_t e;
        issue(3'd1, 0, 40'h40_0000_0000, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        issue(3'd4, 1, 40'h0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || ovf_o !== e.ovf || m_ext_o !== e.ext) begin
            errors++; $display("FAIL shl_ovf: got m=%h ovf=%b ext=%b, want %h %b %b",
                               m_o, ovf_o, m_ext_o, e.m, e.ovf, e.ext);
        end
        issue(3'd0, 3, 40'h0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (ovf_o !== e.ovf || m_o !== e.m) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b m=%h, want %b %h", ovf_o, m_o, e.ovf, e.m);
        end
        issue(3'd4, 45, 40'h0, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || ovf_o !== e.ovf || m_ext_o !== e.ext || obs_lat !== e.lat) begin
            errors++; $display("FAIL shl_long: got m=%h ovf=%b ext=%b lat=%0d, want %h %b %b %0d",
                               m_o, ovf_o, m_ext_o, obs_lat, e.m, e.ovf, e.ext, e.lat);
        end
    endtask

    task automatic test_full_rotate();
        exp_t e;
        issue(3'd1, 0, 40'h12_3456_789A, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        issue(3'd6, 40, 40'h0, 1'b1, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || m_ext_o !== e.ext) begin
            errors++; $display("FAIL rol_full: got m=%h ext=%b, want %h %b", m_o, m_ext_o, e.m, e.ext);
        end
        checks++; if (obs_lat !== e.lat || obs_busy !== e.busy_n || obs_done !== 1) begin
            errors++; $display("FAIL rol_timing: got lat=%0d busy=%0d done=%0d, want %0d %0d 1",
                               obs_lat, obs_busy, obs_done, e.lat, e.busy_n);
        end
        issue(3'd5, 3, 40'h0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || m_ext_o !== e.ext) begin
            errors++; $display("FAIL ror3: got m=%h ext=%b, want %h %b", m_o, m_ext_o, e.m, e.ext);
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        issue(3'd7, 5, 40'hAA_5555_AAAA, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (m_o !== e.m || obs_lat !== e.lat || obs_busy !== e.busy_n) begin
            errors++; $display("FAIL reserved: got m=%h lat=%0d busy=%0d, want %h %0d %0d",
                               m_o, obs_lat, obs_busy, e.m, e.lat, e.busy_n);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(3'd1, 0, 40'hC3_0F0F_1234, 1'b0, 1'b0, 1'b0);
        issue(3'd3, 7, 40'h0, 1'b0, 1'b0, 1'b1);
        issue(3'd2, 2, 40'h0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        e = sb.pop_front();
        e = sb.pop_front();
        checks++; if (m_o !== e.m || m_ext_o !== e.ext || obs_lat !== e.lat) begin
            errors++; $display("FAIL back_to_back: got m=%h ext=%b lat=%0d, want %h %b %0d",
                               m_o, m_ext_o, obs_lat, e.m, e.ext, e.lat);
        end
        checks++; if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_arith_shift();
        test_logical_shift();
        test_shl_ovf();
        test_full_rotate();
        test_reserved();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
